// File: rtl/axi_lite_clint.sv
// AXI4-Lite core-local interruptor: free-running 64-bit mtime, 64-bit mtimecmp
// and msip, driving timer_irq and soft_irq.
// Optional feature: define CLINT_MTIME_WRITE_EN to make the mtime words writable;
// without it, writes to mtime are dropped and answered with SLVERR.
module axi_lite_clint #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arready,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  input  logic                  awvalid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awready,
  input  logic                  wvalid,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  output logic                  wready,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic                  timer_irq,
  output logic                  soft_irq
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [2:0] {SelNone, SelMsip, SelCmpLo, SelCmpHi, SelTimeLo, SelTimeHi} sel_e;

  // Map a byte address onto a register; misaligned offsets never match.
  function automatic sel_e decode_sel(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - ADDR_WIDTH'(BASE_ADDR);
    if (off >= ADDR_WIDTH'(32'h1_0000)) return SelNone;
    case (off[15:0])
      16'h0000: return SelMsip;
      16'h4000: return SelCmpLo;
      16'h4004: return SelCmpHi;
      16'hBFF8: return SelTimeLo;
      16'hBFFC: return SelTimeHi;
      default:  return SelNone;
    endcase
  endfunction

  // Out-of-window beats misalignment; misalignment beats an unlisted offset.
  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr, input sel_e sel);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - ADDR_WIDTH'(BASE_ADDR);
    if (off >= ADDR_WIDTH'(32'h1_0000)) return RespDecerr;
    if (addr[1:0] != 2'b00)             return RespSlverr;
    if (sel == SelNone)                 return RespDecerr;
    return RespOkay;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = st[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  logic                  rvalid_q, aw_held_q, w_held_q, bvalid_q, msip_q;
  logic [31:0]           rdata_q, w_data_q, presc_q;
  logic [1:0]            rresp_q, bresp_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [3:0]            w_strb_q;
  logic [63:0]           mtime_q, mtimecmp_q;

  logic        ar_hs, aw_hs, w_hs, commit, tick, wr_ok, msip_d;
  sel_e        rd_sel, wr_sel;
  logic [1:0]  rd_resp, wr_resp;
  logic [31:0] rd_word, presc_d;
  logic [63:0] mtime_d, mtimecmp_d;

  assign arready   = ~rvalid_q;
  assign awready   = ~aw_held_q;
  assign wready    = ~w_held_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign timer_irq = (mtime_q >= mtimecmp_q);
  assign soft_irq  = msip_q;

  // Address decode, commit decision and register next-state.
  always_comb begin
    ar_hs   = arvalid & ~rvalid_q;
    aw_hs   = awvalid & ~aw_held_q;
    w_hs    = wvalid & ~w_held_q;
    commit  = aw_held_q & w_held_q & ~bvalid_q;
    rd_sel  = decode_sel(araddr);
    rd_resp = decode_resp(araddr, rd_sel);
    wr_sel  = decode_sel(aw_addr_q);
    wr_resp = decode_resp(aw_addr_q, wr_sel);
`ifndef CLINT_MTIME_WRITE_EN
    if (wr_sel == SelTimeLo || wr_sel == SelTimeHi) wr_resp = RespSlverr;
`endif
    wr_ok = commit & (wr_resp == RespOkay);

    rd_word = 32'h0;
    case (rd_sel)
      SelMsip:   rd_word = {31'h0, msip_q};
      SelCmpLo:  rd_word = mtimecmp_q[31:0];
      SelCmpHi:  rd_word = mtimecmp_q[63:32];
      SelTimeLo: rd_word = mtime_q[31:0];
      SelTimeHi: rd_word = mtime_q[63:32];
      default:   rd_word = 32'h0;
    endcase

    tick    = (presc_q == 32'(TICK_DIV - 1));
    presc_d = tick ? 32'h0 : presc_q + 32'h1;
    mtime_d = tick ? mtime_q + 64'h1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_ok) begin
      case (wr_sel)
        SelMsip:   msip_d = merge({31'h0, msip_q}, w_data_q, w_strb_q)[0];
        SelCmpLo:  mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], w_data_q, w_strb_q);
        SelCmpHi:  mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], w_data_q, w_strb_q);
`ifdef CLINT_MTIME_WRITE_EN
        // A write replaces this cycle's tick rather than adding to it.
        SelTimeLo: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], w_data_q, w_strb_q)};
        SelTimeHi: mtime_d = {merge(mtime_q[63:32], w_data_q, w_strb_q), mtime_q[31:0]};
`endif
        default: ;
      endcase
    end
  end

  // Read channel: one outstanding read, data captured at the AR handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      rresp_q  <= RespOkay;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= (rd_resp == RespOkay) ? rd_word : 32'h0;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Write channel: independent AW/W holds, commit once both are full and B is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_resp;
      end else if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Timer, compare and software-interrupt state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= 32'h0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
    end
  end

endmodule
